gumnut_data_mem: RTL

Bus responder for the Gumnut data bus: the slave end of the `data_cyc`/`data_stb`/`data_we`/`data_ack` handshake that the control unit drives as initiator. It holds a byte-addressed scratch RAM and answers reads and writes after a parameterised number of wait states, with one registered `ack` pulse. The control unit's `mem_state` loop depends on this wait behaviour.

---
 rtl/gumnut_bus_pkg.sv | 15 +
 rtl/gumnut_sp_ram.sv | 25 ++
 rtl/gumnut_data_mem.sv | 126 ++++++++++++
 3 files changed

// File: rtl/gumnut_bus_pkg.sv
// Shared types and widths for the Gumnut bus responders (data now, port bus later).
// Holds the responder state encoding and the default bus widths.
package gumnut_bus_pkg;

    localparam int GUMNUT_DATA_W = 8;
    localparam int GUMNUT_ADDR_W = 8;

    typedef enum logic [1:0] {
        RSP_IDLE,
        RSP_WAIT,
        RSP_ACK,
        RSP_DONE
    } rsp_state_e;

endpackage

// File: rtl/gumnut_sp_ram.sv
// Single-port synchronous scratch RAM with registered read data, one-cycle read latency.
// Write-first: a write also presents the new data on dout; contents are never reset.
module gumnut_sp_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[adr] <= din;
            dout       <= din;
        end else begin
            dout       <= mem_q[adr];
        end
    end

endmodule

// File: rtl/gumnut_data_mem.sv
// Gumnut data-bus responder: scratch RAM answering after WAIT_STATES wait cycles with a one-cycle ack.
// Latency request-edge to ack is 1+WAIT_STATES; a held strobe is parked in DONE until it drops.
module gumnut_data_mem
    import gumnut_bus_pkg::*;
#(
    parameter int ADDR_W      = GUMNUT_ADDR_W,
    parameter int DATA_W      = GUMNUT_DATA_W,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_cyc_i,
    input  logic              data_stb_i,
    input  logic              data_we_i,
    input  logic [ADDR_W-1:0] data_adr_i,
    input  logic [DATA_W-1:0] data_dat_i,
    output logic [DATA_W-1:0] data_dat_o,
    output logic              data_ack_o,
    output logic              busy_o
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    rsp_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              ack_q, ack_d;
    logic              req;
    logic              enter_ack;
    logic              rd_ack;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    assign req = data_cyc_i & data_stb_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        we_d      = we_q;
        wdat_d    = wdat_q;
        enter_ack = 1'b0;
        case (state_q)
            RSP_IDLE: begin
                if (req) begin
                    adr_d  = data_adr_i;
                    we_d   = data_we_i;
                    wdat_d = data_dat_i;
                    cnt_d  = WAIT_CNT;
                    if (WAIT_STATES > 0) begin
                        state_d = RSP_WAIT;
                    end else begin
                        state_d   = RSP_ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            RSP_WAIT: begin
                if (!data_cyc_i) begin
                    state_d = RSP_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d   = RSP_ACK;
                        enter_ack = 1'b1;
                    end
                end
            end
            RSP_ACK:  state_d = RSP_DONE;
            RSP_DONE: begin
                if (!data_stb_i || !data_cyc_i) begin
                    state_d = RSP_IDLE;
                end
            end
            default:  state_d = RSP_IDLE;
        endcase
    end

    // The *_d request fields are the inputs in a zero-wait IDLE cycle and the latches otherwise,
    // so the RAM is always accessed on the edge into ACK with the committed request.
    assign ram_we = enter_ack & we_d & ~rst;
    assign ack_d  = enter_ack;
    assign rd_ack = ack_q & ~we_q;
    assign rdat_d = rd_ack ? ram_dout : rdat_q;

    gumnut_sp_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .adr  (adr_d),
        .din  (wdat_d),
        .dout (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RSP_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
        end
    end

    // Read data comes straight from the RAM's output register in a read ACK, else the held copy.
    assign data_dat_o = rd_ack ? ram_dout : rdat_q;
    assign data_ack_o = ack_q;
    assign busy_o     = (state_q == RSP_WAIT) || (state_q == RSP_ACK);

endmodule
